// File: rtl/motor_arm_sequencer.sv
// motor_arm_sequencer: arm/disarm supervisor in front of the four PWM generators.
// Ports: clk, rst (async, active high); rx_valid/throttle_cmd/yaw_cmd receiver frame;
//        motor_cmd_in -> motor_cmd_out (4 x 8b lanes); armed, failsafe, state status.
module motor_arm_sequencer #(
  parameter logic [7:0]  THR_LOW  = 8'd10,
  parameter logic [7:0]  YAW_HI   = 8'd240,
  parameter logic [7:0]  YAW_LO   = 8'd15,
  parameter int unsigned ARM_HOLD = 50,
  parameter logic [7:0]  IDLE     = 8'd20,
  parameter int unsigned RAMP_DIV = 1000,
  parameter int unsigned TIMEOUT  = 500000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_valid,
  input  logic [7:0]  throttle_cmd,
  input  logic [7:0]  yaw_cmd,
  input  logic [31:0] motor_cmd_in,
  output logic [31:0] motor_cmd_out,
  output logic        armed,
  output logic        failsafe,
  output logic [1:0]  state
);

  localparam int GW = $clog2(ARM_HOLD + 1);
  localparam int WW = $clog2(TIMEOUT + 1);
  localparam int RW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;

  localparam logic [GW-1:0] GMAX = GW'(ARM_HOLD);
  localparam logic [WW-1:0] WMAX = WW'(TIMEOUT);
  localparam logic [RW-1:0] RMAX = RW'(RAMP_DIV - 1);

  typedef enum logic [1:0] {
    S_DISARMED = 2'b00,
    S_SPINUP   = 2'b01,
    S_ARMED    = 2'b10,
    S_FAILSAFE = 2'b11
  } state_t;

  state_t        state_q, state_n;
  logic [GW-1:0] gcnt_q, gcnt_n;
  logic [WW-1:0] wcnt_q, wcnt_n;
  logic [RW-1:0] rdiv_q, rdiv_n;
  logic [7:0]    ramp_q, ramp_n;
  logic [31:0]   out_q, out_n;

  logic arm_g, disarm_g, qual;
  logic timeout, step, chg;

  assign arm_g    = (throttle_cmd <= THR_LOW) && (yaw_cmd >= YAW_HI);
  assign disarm_g = (throttle_cmd <= THR_LOW) && (yaw_cmd <= YAW_LO);
  assign timeout  = (wcnt_q == WMAX);
  assign step     = (rdiv_q == RMAX);
  assign chg      = (state_n != state_q);

  // Only DISARMED and ARMED have a gesture; other states just clear the count.
  always_comb begin
    qual = 1'b0;
    unique case (1'b1)
      (state_q == S_DISARMED): qual = arm_g;
      (state_q == S_ARMED):    qual = disarm_g;
      default:                 qual = 1'b0;
    endcase
  end

  always_comb begin
    state_n = state_q;
    case (state_q)
      S_DISARMED:
        if (gcnt_q == GMAX) state_n = S_SPINUP;
      S_SPINUP:
        if (timeout) state_n = S_FAILSAFE;
        else if (ramp_q == IDLE) state_n = S_ARMED;
      S_ARMED:
        if (timeout) state_n = S_FAILSAFE;
        else if (gcnt_q == GMAX) state_n = S_DISARMED;
      S_FAILSAFE:
        if (out_q == '0) state_n = S_DISARMED;
      default:
        state_n = S_DISARMED;
    endcase
  end

  always_comb begin
    gcnt_n = gcnt_q;
    if (chg) begin
      gcnt_n = '0;
    end else if (rx_valid) begin
      if (!qual) gcnt_n = '0;
      else if (gcnt_q != GMAX) gcnt_n = gcnt_q + GW'(1);
    end
  end

  always_comb begin
    wcnt_n = wcnt_q;
    if (rx_valid) wcnt_n = '0;
    else if (!timeout) wcnt_n = wcnt_q + WW'(1);
  end

  // Step timer and ramp restart from zero on every state entry.
  always_comb begin
    rdiv_n = '0;
    ramp_n = '0;
    if (!chg && (state_q == S_SPINUP ||
                 state_q == S_FAILSAFE)) begin
      rdiv_n = step ? '0 : rdiv_q + RW'(1);
      ramp_n = ramp_q;
      if (step && state_q == S_SPINUP &&
          ramp_q != 8'hff)
        ramp_n = ramp_q + 8'd1;
    end
  end

  // Outputs follow the state being entered, so a transition edge
  // already presents the new state's commands.
  always_comb begin
    out_n = '0;
    for (int i = 0; i < 4; i++) begin
      case (state_n)
        S_SPINUP:
          out_n[8*i +: 8] = ramp_n;
        S_ARMED:
          out_n[8*i +: 8] =
            (motor_cmd_in[8*i +: 8] > IDLE) ?
            motor_cmd_in[8*i +: 8] : IDLE;
        S_FAILSAFE:
          if (!chg && step &&
              out_q[8*i +: 8] != 8'd0)
            out_n[8*i +: 8] = out_q[8*i +: 8] - 8'd1;
          else
            out_n[8*i +: 8] = out_q[8*i +: 8];
        default:
          out_n[8*i +: 8] = 8'd0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_DISARMED;
      gcnt_q  <= '0;
      wcnt_q  <= '0;
      rdiv_q  <= '0;
      ramp_q  <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_n;
      gcnt_q  <= gcnt_n;
      wcnt_q  <= wcnt_n;
      rdiv_q  <= rdiv_n;
      ramp_q  <= ramp_n;
      out_q   <= out_n;
    end
  end

  assign motor_cmd_out = out_q;
  assign armed         = (state_q == S_ARMED);
  assign failsafe      = (state_q == S_FAILSAFE);
  assign state         = state_q;

endmodule

// File: tb/tb_motor_arm_sequencer.sv
// tb_motor_arm_sequencer: scenario bench for motor_arm_sequencer.
// Expected values come from the arming rules computed with plain arithmetic.
module tb_motor_arm_sequencer;

  localparam int HOLD   = 3;
  localparam int IDLE_V = 4;
  localparam int DIV    = 2;
  localparam int DIV2   = 8;
  localparam int TMO    = 20;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx_valid = 1'b0;
  logic        rx_valid2 = 1'b0;
  logic [7:0]  throttle_cmd = '0;
  logic [7:0]  yaw_cmd = '0;
  logic [31:0] motor_cmd_in = '0;
  logic [31:0] motor_cmd_out, motor_cmd_out2;
  logic        armed, failsafe, armed2, failsafe2;
  logic [1:0]  state, state2;

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  motor_arm_sequencer #(
    .ARM_HOLD(HOLD), .IDLE(8'd4),
    .RAMP_DIV(DIV), .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .rst(rst),
    .rx_valid(rx_valid),
    .throttle_cmd(throttle_cmd),
    .yaw_cmd(yaw_cmd),
    .motor_cmd_in(motor_cmd_in),
    .motor_cmd_out(motor_cmd_out),
    .armed(armed), .failsafe(failsafe),
    .state(state)
  );

  // Slower ramp so a timeout can land mid-spinup.
  motor_arm_sequencer #(
    .ARM_HOLD(HOLD), .IDLE(8'd4),
    .RAMP_DIV(DIV2), .TIMEOUT(TMO)
  ) dut2 (
    .clk(clk), .rst(rst),
    .rx_valid(rx_valid2),
    .throttle_cmd(throttle_cmd),
    .yaw_cmd(yaw_cmd),
    .motor_cmd_in(motor_cmd_in),
    .motor_cmd_out(motor_cmd_out2),
    .armed(armed2), .failsafe(failsafe2),
    .state(state2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] t,
                      input logic [7:0] y);
    rx_valid = 1'b1;
    throttle_cmd = t;
    yaw_cmd = y;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic reset_dut();
    rx_valid = 1'b0;
    rx_valid2 = 1'b0;
    throttle_cmd = '0;
    yaw_cmd = '0;
    motor_cmd_in = '0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    reset_dut();
    vectors += 4;
    if (state !== 2'b00) begin
      errors++;
      $display("FAIL reset_state: got %b want 00", state);
    end
    if (motor_cmd_out !== 32'h0) begin
      errors++;
      $display("FAIL reset_out: got %h want 0", motor_cmd_out);
    end
    if (armed !== 1'b0) begin
      errors++;
      $display("FAIL reset_armed: got %b want 0", armed);
    end
    if (failsafe !== 1'b0) begin
      errors++;
      $display("FAIL reset_fs: got %b want 0", failsafe);
    end
  endtask

  // Arm from DISARMED with motor_cmd_in=0 and check the ramp.
  task automatic arm_seq();
    logic [7:0] e;
    motor_cmd_in = '0;
    for (int i = 0; i < HOLD; i++) send(8'd5, 8'd250);
    tick();
    for (int k = 0; k <= IDLE_V * DIV; k++) begin
      if (k > 0) tick();
      e = 8'(k / DIV);
      vectors += 2;
      if (state !== 2'b01) begin
        errors++;
        $display("FAIL ramp_state k=%0d: got %b want 01", k, state);
      end
      if (motor_cmd_out !== {4{e}}) begin
        errors++;
        $display("FAIL ramp_out k=%0d: got %h want %h",
                 k, motor_cmd_out, {4{e}});
      end
    end
    tick();
    vectors += 3;
    if (state !== 2'b10) begin
      errors++;
      $display("FAIL armed_state: got %b want 10", state);
    end
    if (armed !== 1'b1) begin
      errors++;
      $display("FAIL armed_flag: got %b want 1", armed);
    end
    if (motor_cmd_out !== 32'h04040404) begin
      errors++;
      $display("FAIL armed_idle: got %h want 04040404", motor_cmd_out);
    end
  endtask

  task automatic test_arm_ramp();
    reset_dut();
    arm_seq();
  endtask

  task automatic test_no_arm();
    reset_dut();
    send(8'd5, 8'd250);
    send(8'd5, 8'd250);
    send(8'd5, 8'd100);
    send(8'd10, 8'd240);
    send(8'd10, 8'd240);
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++;
      if (state !== 2'b00) begin
        errors++;
        $display("FAIL no_arm %0d: got %b want 00", i, state);
      end
    end
    send(8'd10, 8'd240);
    vectors++;
    if (state !== 2'b00) begin
      errors++;
      $display("FAIL arm_edge: got %b want 00", state);
    end
    tick();
    vectors++;
    if (state !== 2'b01) begin
      errors++;
      $display("FAIL arm_boundary: got %b want 01", state);
    end
  endtask

  task automatic test_gesture_random();
    logic [7:0] t, y;
    int run;
    bit q, done;
    for (int trial = 0; trial < 6; trial++) begin
      reset_dut();
      run = 0;
      done = 0;
      for (int f = 0; f < 40 && !done; f++) begin
        t = ($urandom_range(0, 9) < 7) ?
            8'($urandom_range(0, 12)) : 8'($urandom_range(0, 255));
        y = ($urandom_range(0, 9) < 7) ?
            8'($urandom_range(236, 255)) : 8'($urandom_range(0, 255));
        q = (t <= 8'd10) && (y >= 8'd240);
        run = q ? run + 1 : 0;
        send(t, y);
        vectors++;
        if (state !== 2'b00) begin
          errors++;
          $display("FAIL gest_frame t%0d f%0d: got %b want 00",
                   trial, f, state);
        end
        if (run == HOLD) begin
          tick();
          vectors++;
          if (state !== 2'b01) begin
            errors++;
            $display("FAIL gest_arm t%0d f%0d: got %b want 01",
                     trial, f, state);
          end
          done = 1;
        end else begin
          repeat ($urandom_range(0, 2)) begin
            tick();
            vectors++;
            if (state !== 2'b00) begin
              errors++;
              $display("FAIL gest_gap t%0d: got %b want 00",
                       trial, state);
            end
          end
        end
      end
    end
  endtask

  task automatic test_passthrough();
    logic [31:0] e;
    logic [7:0] lane;
    rx_valid = 1'b1;
    throttle_cmd = 8'd100;
    yaw_cmd = 8'd128;
    motor_cmd_in = {8'd2, 8'd100, 8'd4, 8'd0};
    tick();
    vectors++;
    if (motor_cmd_out !== {8'd4, 8'd100, 8'd4, 8'd4}) begin
      errors++;
      $display("FAIL pass_dir: got %h want 04640404", motor_cmd_out);
    end
    for (int n = 0; n < 24; n++) begin
      motor_cmd_in = $urandom;
      for (int i = 0; i < 4; i++)
        if ($urandom_range(0, 2) == 0)
          motor_cmd_in[8*i +: 8] = 8'($urandom_range(0, 6));
      for (int i = 0; i < 4; i++) begin
        lane = motor_cmd_in[8*i +: 8];
        e[8*i +: 8] = (lane > 8'(IDLE_V)) ? lane : 8'(IDLE_V);
      end
      tick();
      vectors += 2;
      if (motor_cmd_out !== e) begin
        errors++;
        $display("FAIL pass_rnd %0d: got %h want %h",
                 n, motor_cmd_out, e);
      end
      if (state !== 2'b10) begin
        errors++;
        $display("FAIL pass_state %0d: got %b want 10", n, state);
      end
    end
    rx_valid = 1'b0;
  endtask

  task automatic test_disarm();
    motor_cmd_in = 32'h30303030;
    send(8'd0, 8'd0);
    send(8'd10, 8'd15);
    send(8'd3, 8'd7);
    vectors += 2;
    if (state !== 2'b10) begin
      errors++;
      $display("FAIL disarm_edge: got %b want 10", state);
    end
    if (motor_cmd_out !== 32'h30303030) begin
      errors++;
      $display("FAIL disarm_pre: got %h want 30303030", motor_cmd_out);
    end
    tick();
    vectors += 3;
    if (state !== 2'b00) begin
      errors++;
      $display("FAIL disarm_state: got %b want 00", state);
    end
    if (motor_cmd_out !== 32'h0) begin
      errors++;
      $display("FAIL disarm_out: got %h want 0", motor_cmd_out);
    end
    if (armed !== 1'b0) begin
      errors++;
      $display("FAIL disarm_flag: got %b want 0", armed);
    end
  endtask

  task automatic test_failsafe();
    int lv[4];
    int v;
    logic [31:0] e;
    lv = '{4, 4, 6, 8};
    reset_dut();
    arm_seq();
    motor_cmd_in = {8'd8, 8'd6, 8'd4, 8'd4};
    throttle_cmd = 8'd100;
    yaw_cmd = 8'd128;
    rx_valid = 1'b1;
    repeat (3) tick();
    rx_valid = 1'b0;
    for (int i = 1; i <= TMO; i++) begin
      tick();
      vectors++;
      if (state !== 2'b10 ||
          motor_cmd_out !== 32'h08060404) begin
        errors++;
        $display("FAIL fs_wait %0d: got %b/%h want 10/08060404",
                 i, state, motor_cmd_out);
      end
    end
    tick();
    vectors += 3;
    if (state !== 2'b11) begin
      errors++;
      $display("FAIL fs_enter: got %b want 11", state);
    end
    if (failsafe !== 1'b1 || armed !== 1'b0) begin
      errors++;
      $display("FAIL fs_flags: got fs=%b arm=%b want 1/0",
               failsafe, armed);
    end
    if (motor_cmd_out !== 32'h08060404) begin
      errors++;
      $display("FAIL fs_latch: got %h want 08060404", motor_cmd_out);
    end
    motor_cmd_in = $urandom;
    for (int j = 1; j <= 16; j++) begin
      rx_valid = (j inside {[3:5], [9:11]});
      throttle_cmd = 8'd2;
      yaw_cmd = 8'd250;
      for (int i = 0; i < 4; i++) begin
        v = lv[i] - j / DIV;
        if (v < 0) v = 0;
        e[8*i +: 8] = 8'(v);
      end
      tick();
      vectors += 2;
      if (motor_cmd_out !== e) begin
        errors++;
        $display("FAIL fs_ramp j=%0d: got %h want %h",
                 j, motor_cmd_out, e);
      end
      if (state !== 2'b11) begin
        errors++;
        $display("FAIL fs_hold j=%0d: got %b want 11", j, state);
      end
    end
    rx_valid = 1'b0;
    tick();
    vectors += 2;
    if (state !== 2'b00 || failsafe !== 1'b0) begin
      errors++;
      $display("FAIL fs_exit: got %b fs=%b want 00 fs=0",
               state, failsafe);
    end
    if (motor_cmd_out !== 32'h0) begin
      errors++;
      $display("FAIL fs_exit_out: got %h want 0", motor_cmd_out);
    end
    repeat (3) tick();
    vectors++;
    if (state !== 2'b00) begin
      errors++;
      $display("FAIL fs_no_rearm: got %b want 00", state);
    end
  endtask

  task automatic test_spinup_timeout();
    logic [7:0] e;
    reset_dut();
    throttle_cmd = 8'd5;
    yaw_cmd = 8'd250;
    rx_valid2 = 1'b1;
    repeat (HOLD) tick();
    rx_valid2 = 1'b0;
    tick();
    for (int k = 0; k < TMO; k++) begin
      if (k > 0) tick();
      e = 8'(k / DIV2);
      vectors++;
      if (state2 !== 2'b01 || motor_cmd_out2 !== {4{e}}) begin
        errors++;
        $display("FAIL su_ramp k=%0d: got %b/%h want 01/%h",
                 k, state2, motor_cmd_out2, {4{e}});
      end
    end
    tick();
    vectors += 2;
    if (state2 !== 2'b11 || failsafe2 !== 1'b1) begin
      errors++;
      $display("FAIL su_to_fs: got %b fs=%b want 11 fs=1",
               state2, failsafe2);
    end
    if (motor_cmd_out2 !== 32'h02020202) begin
      errors++;
      $display("FAIL su_latch: got %h want 02020202", motor_cmd_out2);
    end
    for (int j = 1; j <= 2 * DIV2; j++) begin
      tick();
      e = 8'(2 - j / DIV2);
      vectors++;
      if (state2 !== 2'b11 || motor_cmd_out2 !== {4{e}}) begin
        errors++;
        $display("FAIL su_down j=%0d: got %b/%h want 11/%h",
                 j, state2, motor_cmd_out2, {4{e}});
      end
    end
    tick();
    vectors++;
    if (state2 !== 2'b00) begin
      errors++;
      $display("FAIL su_disarm: got %b want 00", state2);
    end
  endtask

  task automatic test_reset_mid();
    reset_dut();
    arm_seq();
    rx_valid = 1'b1;
    throttle_cmd = 8'd100;
    yaw_cmd = 8'd128;
    motor_cmd_in = 32'h80808080;
    tick();
    tick();
    vectors++;
    if (motor_cmd_out !== 32'h80808080) begin
      errors++;
      $display("FAIL mid_pre: got %h want 80808080", motor_cmd_out);
    end
    #2 rst = 1'b1;
    #1;
    vectors += 2;
    if (motor_cmd_out !== 32'h0 || state !== 2'b00) begin
      errors++;
      $display("FAIL mid_async: got %h/%b want 0/00",
               motor_cmd_out, state);
    end
    if (armed !== 1'b0) begin
      errors++;
      $display("FAIL mid_armed: got %b want 0", armed);
    end
    rx_valid = 1'b0;
    #2 rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      vectors++;
      if (state !== 2'b00 || motor_cmd_out !== 32'h0) begin
        errors++;
        $display("FAIL mid_after %0d: got %b/%h want 00/0",
                 i, state, motor_cmd_out);
      end
    end
  endtask

  initial begin
    test_reset();
    test_no_arm();
    test_gesture_random();
    test_arm_ramp();
    test_passthrough();
    test_disarm();
    test_failsafe();
    test_spinup_timeout();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1);
  end

endmodule

// File: doc/motor_arm_sequencer.md
# motor_arm_sequencer

Supervisory controller between the per-motor offset summers and the four PWM generators. Owns the arm/disarm state machine: gates motor commands to zero while disarmed, ramps motors to idle on arming, and on receiver loss ramps motors down to zero and disarms. All motor commands to the PWM generators pass through this block.

## Interface
- THR_LOW, 8'd10: throttle at or below this is "stick low"
- YAW_HI, 8'd240: yaw at or above this is the arm gesture
- YAW_LO, 8'd15: yaw at or below this is the disarm gesture
- ARM_HOLD, 50: consecutive qualifying receiver frames required for a gesture (≥1)
- IDLE, 8'd20: minimum motor command while armed
- RAMP_DIV, 1000: clk cycles per ramp step (≥1)
- TIMEOUT, 500000: clk cycles without rx_valid before failsafe (≥2)
- clk  in  1  system clock, single domain; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- rx_valid  in  1  one-cycle pulse when a new receiver frame is decoded
- throttle_cmd  in  8  decoded throttle; sampled only when rx_valid=1
- yaw_cmd  in  8  decoded yaw; sampled only when rx_valid=1
- motor_cmd_in  in  32  summed commands; motor1 [7:0], motor2 [15:8], motor3 [23:16], motor4 [31:24]
- motor_cmd_out  out  32  gated commands to PWM generators, same packing
- armed  out  1  high in ARMED only
- failsafe  out  1  high in FAILSAFE only
- state  out  2  00 DISARMED, 01 SPINUP, 10 ARMED, 11 FAILSAFE

## Operation
- Gesture counter gcnt: on each rx_valid, if the current state's gesture condition holds, gcnt increments (saturating at ARM_HOLD); otherwise gcnt clears. Unchanged on cycles without rx_valid. Clears on every state change.
- Arm condition: throttle_cmd ≤ THR_LOW and yaw_cmd ≥ YAW_HI. Disarm condition: throttle_cmd ≤ THR_LOW and yaw_cmd ≤ YAW_LO. Comparisons unsigned, inclusive.
- Watchdog wcnt: clears to 0 on rx_valid, otherwise increments, saturating at TIMEOUT. Timeout asserts when wcnt == TIMEOUT.
- Ramp value ramp[7:0] with step timer rdiv counting 0..RAMP_DIV-1; one step when rdiv wraps.
- DISARMED: motor_cmd_out = 0. gcnt reaching ARM_HOLD (on an rx_valid cycle) -> SPINUP with ramp=0. Timeout has no effect.
- SPINUP: all four outputs = ramp; ramp +1 per step; when ramp == IDLE -> ARMED. Timeout -> FAILSAFE (takes precedence over ramp completion in the same cycle).
- ARMED: each motor output = max(motor_cmd_in[motor], IDLE), independently per motor. gcnt (disarm) reaching ARM_HOLD -> DISARMED immediately (outputs 0 next cycle). Timeout -> FAILSAFE; timeout wins over a simultaneous disarm gesture.
- FAILSAFE: on entry, each motor's current output is latched; each motor decrements by 1 per step, floored at 0. When all four are 0 -> DISARMED. rx_valid recovery does not leave FAILSAFE; re-arming requires a full gesture from DISARMED.
- Arithmetic: 8-bit unsigned throughout; no wrap below 0 or above 255.

## Timing
- Reset: state=DISARMED, motor_cmd_out=0, armed=0, failsafe=0, gcnt=0, wcnt=0, ramp=0, rdiv=0. Reset mid-ramp or mid-failsafe drops outputs to 0 asynchronously.
- All outputs registered. ARMED passthrough latency: motor_cmd_in at edge N visible on motor_cmd_out after edge N+1.
- State transitions take effect one edge after the qualifying condition; armed/failsafe/state change on the same edge as state.
- Arm: the ARM_HOLD-th qualifying rx_valid at edge N -> state=SPINUP after edge N+1.
- SPINUP duration: IDLE×RAMP_DIV cycles (+1 transition cycle). FAILSAFE duration: max latched value × RAMP_DIV cycles.
- Timeout: TIMEOUT cycles after the last rx_valid, state becomes FAILSAFE on the following edge.

## Test plan
(Bench parameters: ARM_HOLD=3, IDLE=4, RAMP_DIV=2, TIMEOUT=20.)
- Reset asserted mid-ARMED with motor_cmd_in=0x80808080 -> motor_cmd_out=0, state=00 immediately; stays DISARMED after release.
- Three rx_valid frames thr=5, yaw=250 -> SPINUP; outputs step 0,1,2,3,4 every 2 cycles; state=10 when outputs reach 4. Two frames then one with yaw=100 -> gcnt clears, no arm.
- ARMED with motor_cmd_in={8'd2,8'd100,8'd4,8'd0} -> motor_cmd_out={8'd4,8'd100,8'd4,8'd4} one cycle later.
- ARMED, three frames thr=0, yaw=0 -> DISARMED, outputs 0 next cycle, armed=0.
- ARMED at outputs {8,6,4,4}, stop rx_valid -> after 20 cycles failsafe=1; outputs decrement every 2 cycles; DISARMED when all 0 (16 cycles); rx_valid during descent ignored.
- Timeout during SPINUP at ramp=2 -> FAILSAFE, ramp down 2->0, then DISARMED.
